axi_buffer_rr_arbiter: RTL and testbench



---
 rtl/axi_buffer_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_axi_buffer_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_buffer_rr_arbiter.sv
// Burst-granular round-robin arbiter sharing one axi_buffer input port between N_REQ requesters.
// Optional macro AXI_BUFFER_ARB_PRIO0_EN gives requester 0 absolute priority in IDLE.
module axi_buffer_rr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LOG_N_REQ  = $clog2(N_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]            req_last_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic                        valid_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        last_o,
    output logic [LOG_N_REQ-1:0]        id_o,
    input  logic                        ready_i
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e               state_q, state_d;
    logic [LOG_N_REQ-1:0] rr_ptr_q, rr_ptr_d;
    logic [LOG_N_REQ-1:0] lock_id_q, lock_id_d;

    logic                 found;
    logic [LOG_N_REQ-1:0] winner;
    logic [LOG_N_REQ-1:0] sel;
    logic [LOG_N_REQ-1:0] cur_id;
    logic                 active;
    logic                 handshake;
    logic                 ptr_update;

    function automatic logic [LOG_N_REQ-1:0] wrap_inc(input logic [LOG_N_REQ-1:0] idx);
        return (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    // Circular search starting at rr_ptr; N_REQ need not be a power of two.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sel    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel = LOG_N_REQ'((int'(rr_ptr_q) + i) % N_REQ);
            if (!found && req_valid_i[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
`ifdef AXI_BUFFER_ARB_PRIO0_EN
        if (req_valid_i[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
    end

    assign cur_id    = (state_q == LOCKED) ? lock_id_q : winner;
    assign active    = rst_ni && ((state_q == LOCKED) || found);
    assign handshake = valid_o && ready_i;

`ifdef AXI_BUFFER_ARB_PRIO0_EN
    // Bursts of the priority requester leave the rotation untouched.
    assign ptr_update = (cur_id != '0);
`else
    assign ptr_update = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    // An unaccepted beat in IDLE also locks, so the presented beat stays stable.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    if (handshake && last_o) begin
                        if (ptr_update) rr_ptr_d = wrap_inc(winner);
                    end else begin
                        state_d   = LOCKED;
                        lock_id_d = winner;
                    end
                end
            end
            LOCKED: begin
                if (handshake && last_o) begin
                    state_d = IDLE;
                    if (ptr_update) rr_ptr_d = wrap_inc(lock_id_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_o     = 1'b0;
        data_o      = '0;
        last_o      = 1'b0;
        id_o        = '0;
        req_ready_o = '0;
        if (active) begin
            valid_o             = (state_q == LOCKED) ? req_valid_i[cur_id] : 1'b1;
            data_o              = req_data_i[int'(cur_id)*DATA_WIDTH +: DATA_WIDTH];
            last_o              = req_last_i[cur_id];
            id_o                = cur_id;
            req_ready_o[cur_id] = ready_i;
        end
    end

endmodule

// File: tb/tb_axi_buffer_rr_arbiter.sv
// Self-checking bench for axi_buffer_rr_arbiter: directed vector table, hand-written
// reset/priority sequence, then randomized traffic against a behavioural model.
module tb_axi_buffer_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int LW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            ready = 1'b0;
    logic [N-1:0]    req_ready;
    logic            valid;
    logic [DW-1:0]   data;
    logic            last;
    logic [LW-1:0]   id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_buffer_rr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .LOG_N_REQ(LW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .valid_o     (valid),
        .data_o      (data),
        .last_o      (last),
        .id_o        (id),
        .ready_i     (ready)
    );

    typedef struct {
        logic         rst_n;
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         ready;
        logic         exp_valid;
        int           exp_id;
        logic [N-1:0] exp_ready;
    } vec_t;

    vec_t tbl[21];

    // Reference model state: lock flag, lock owner and round-robin pointer.
    bit           m_locked, n_locked;
    int           m_owner, n_owner, m_ptr, n_ptr;
    logic         e_valid, e_last, e_care;
    int           e_id;
    logic [DW-1:0] e_data;
    logic [N-1:0] e_ready;

    function automatic logic [DW-1:0] data_of(input int k);
        return {16'hC0DE, 16'(k * 16'h1111)};
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy);
        rst_n     = r;
        req_valid = v;
        req_last  = l;
        ready     = rdy;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input string tag, input logic ev, input int eid, input logic [N-1:0] erdy);
        check_output({tag, ".valid_o"}, 64'(valid), 64'(ev));
        check_output({tag, ".req_ready_o"}, 64'(req_ready), 64'(erdy));
        check_output({tag, ".id_o"}, 64'(id), ev ? 64'(eid) : 64'd0);
        check_output({tag, ".data_o"}, 64'(data), ev ? 64'(data_of(eid)) : 64'd0);
        check_output({tag, ".last_o"}, 64'(last), ev ? 64'(req_last[eid]) : 64'd0);
    endtask

    // Behavioural model: arbitration rules expressed with a candidate order list.
    task automatic model_eval();
        int order[$];
        int w;
        e_valid = 1'b0; e_id = 0; e_data = '0; e_last = 1'b0; e_ready = '0; e_care = 1'b1;
        n_locked = m_locked; n_owner = m_owner; n_ptr = m_ptr;
        if (!rst_n) begin
            n_locked = 0; n_owner = 0; n_ptr = 0;
        end else if (m_locked) begin
            e_valid          = req_valid[m_owner];
            e_care           = e_valid;
            e_id             = m_owner;
            e_data           = req_data[m_owner*DW +: DW];
            e_last           = req_last[m_owner];
            e_ready[m_owner] = ready;
            if (e_valid && ready && e_last) begin
                n_locked = 0;
`ifdef AXI_BUFFER_ARB_PRIO0_EN
                if (m_owner != 0) n_ptr = (m_owner + 1) % N;
`else
                n_ptr = (m_owner + 1) % N;
`endif
            end
        end else begin
            w = -1;
            for (int i = 0; i < N; i++) order.push_back((m_ptr + i) % N);
            foreach (order[j]) if (w < 0 && req_valid[order[j]]) w = order[j];
`ifdef AXI_BUFFER_ARB_PRIO0_EN
            if (req_valid[0]) w = 0;
`endif
            if (w >= 0) begin
                e_valid    = 1'b1;
                e_id       = w;
                e_data     = req_data[w*DW +: DW];
                e_last     = req_last[w];
                e_ready[w] = ready;
                if (ready && req_last[w]) begin
`ifdef AXI_BUFFER_ARB_PRIO0_EN
                    if (w != 0) n_ptr = (w + 1) % N;
`else
                    n_ptr = (w + 1) % N;
`endif
                end else begin
                    n_locked = 1;
                    n_owner  = w;
                end
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 0, 4'b0000};
        tbl[1]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 0, 4'b0001};
        tbl[2]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 1, 4'b0010};
        tbl[3]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2, 4'b0100};
        tbl[4]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 3, 4'b1000};
        tbl[5]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 0, 4'b0001};
        tbl[6]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 1, 4'b0010};
        tbl[7]  = '{1'b1, 4'b0111, 4'b0011, 1'b1, 1'b1, 2, 4'b0100};
        tbl[8]  = '{1'b1, 4'b0111, 4'b0011, 1'b1, 1'b1, 2, 4'b0100};
        tbl[9]  = '{1'b1, 4'b0111, 4'b0111, 1'b1, 1'b1, 2, 4'b0100};
        tbl[10] = '{1'b1, 4'b0011, 4'b0011, 1'b1, 1'b1, 0, 4'b0001};
        tbl[11] = '{1'b1, 4'b0010, 4'b0010, 1'b0, 1'b1, 1, 4'b0000};
        tbl[12] = '{1'b1, 4'b0010, 4'b0010, 1'b0, 1'b1, 1, 4'b0000};
        tbl[13] = '{1'b1, 4'b0011, 4'b0011, 1'b0, 1'b1, 1, 4'b0000};
        tbl[14] = '{1'b1, 4'b0011, 4'b0011, 1'b0, 1'b1, 1, 4'b0000};
        tbl[15] = '{1'b1, 4'b0011, 4'b0011, 1'b1, 1'b1, 1, 4'b0010};
        tbl[16] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 0, 4'b0001};
        tbl[17] = '{1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 2, 4'b0100};
        tbl[18] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1, 3, 4'b1000};
        tbl[19] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 0, 4'b0001};
        tbl[20] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 0, 4'b0000};

        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = data_of(k);
        next_cycle();

        $display("[TB] directed vector table");
        for (int i = 0; i < 21; i++) begin
            apply_stimulus(tbl[i].rst_n, tbl[i].valid, tbl[i].last, tbl[i].ready);
            check_row($sformatf("tbl[%0d]", i), tbl[i].exp_valid, tbl[i].exp_id, tbl[i].exp_ready);
            next_cycle();
        end

        $display("[TB] reset mid-burst and priority sequence");
        apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
        check_row("rst_idle", 1'b0, 0, 4'b0000);
        next_cycle();
        apply_stimulus(1'b1, 4'b0100, 4'b0000, 1'b1);
        check_row("burst_beat1", 1'b1, 2, 4'b0100);
        next_cycle();
        apply_stimulus(1'b1, 4'b0100, 4'b0000, 1'b1);
        check_row("burst_beat2", 1'b1, 2, 4'b0100);
        next_cycle();
        apply_stimulus(1'b0, 4'b0101, 4'b0101, 1'b1);
        check_row("rst_mid_burst", 1'b0, 0, 4'b0000);
        next_cycle();
        apply_stimulus(1'b1, 4'b0101, 4'b0101, 1'b1);
        check_row("after_rst_grant", 1'b1, 0, 4'b0001);
        next_cycle();
        apply_stimulus(1'b1, 4'b0010, 4'b0010, 1'b1);
        check_row("ptr_to_2", 1'b1, 1, 4'b0010);
        next_cycle();
        apply_stimulus(1'b1, 4'b0101, 4'b0101, 1'b1);
`ifdef AXI_BUFFER_ARB_PRIO0_EN
        check_row("ptr2_req0_req2", 1'b1, 0, 4'b0001);
`else
        check_row("ptr2_req0_req2", 1'b1, 2, 4'b0100);
`endif
        next_cycle();

        $display("[TB] randomized traffic against model");
        m_locked = 0; m_owner = 0; m_ptr = 0;
        for (int c = 0; c < 600; c++) begin
            req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            apply_stimulus((c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0),
                           4'($urandom()), 4'($urandom()), ($urandom_range(0, 3) != 0));
            model_eval();
            check_output($sformatf("rnd[%0d].valid_o", c), 64'(valid), 64'(e_valid));
            check_output($sformatf("rnd[%0d].req_ready_o", c), 64'(req_ready), 64'(e_ready));
            if (e_care) begin
                check_output($sformatf("rnd[%0d].id_o", c), 64'(id), 64'(e_id));
                check_output($sformatf("rnd[%0d].data_o", c), 64'(data), 64'(e_data));
                check_output($sformatf("rnd[%0d].last_o", c), 64'(last), 64'(e_last));
            end
            next_cycle();
            m_locked = n_locked; m_owner = n_owner; m_ptr = n_ptr;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
